xor_dec: RTL and testbench
==========================

# xor_dec

Byte-stream XOR decryptor: the receive-side counterpart of the team's XOR encryption path. It takes ciphertext bytes over a valid/ready handshake and XORs each byte with a keystream from an 8-bit LFSR seeded by `SV`. It returns plaintext bytes over a second valid/ready handshake, one registered stage deep. Frames are fixed-length; after each frame the block stops and waits for a key reload. The matching encoder uses the identical keystream definition from the shared package.

## Interface
Parameters:
- `FRAME_LEN`, default 16: bytes per frame, legal range 1..255.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `SV`  in  8  key seed; sampled only while `load`=1.
- `load`  in  1  latch seed, clear the byte count, enter RUN.
- `en`  in  1  global enable; 0 blocks input acceptance and does not alter state.
- `IN`  in  8  ciphertext byte.
- `in_valid`  in  1  `IN` is valid.
- `in_ready`  out  1  block accepts `IN` this cycle.
- `Out`  out  8  plaintext byte.
- `out_valid`  out  1  `Out` holds a valid byte.
- `out_ready`  in  1  sink takes `Out` this cycle.
- `byte_cnt`  out  8  bytes accepted in the current frame.
- `frame_done`  out  1  high while in state DONE.

## Operation
- FSM states and transitions:
  - IDLE is the reset state; no key is loaded and `in_ready`=0.
  - RUN accepts bytes.
  - DONE: all `FRAME_LEN` bytes have been accepted; `in_ready`=0 and `frame_done`=1.
  - Any state goes to RUN when `load`=1.
  - RUN goes to DONE on the acceptance that makes `byte_cnt` reach `FRAME_LEN`.
- Keystream: `key` register, Fibonacci LFSR for x^8+x^6+x^5+x^4+1.
  - next = {key[6:0], key[7]^key[5]^key[4]^key[3]}.
  - Seed 0x00 is replaced by 0x01, which prevents lock-up.
  - The byte accepted at frame index n uses key_n, with key_0 = seed.
  - The LFSR advances exactly once per accepted byte and never otherwise.
- Transfer condition: `in_valid` && `in_ready`.
  - `in_ready` = (state==RUN) && `en` && !`load` && (!`out_valid` || `out_ready`).
  - On transfer: `Out` <= `IN` ^ `key`; `out_valid` <= 1; `byte_cnt` += 1.
- `out_valid` clears when `out_ready`=1 and no new transfer occurs in the same cycle.
- `en`=0: no transfer takes place. A pending `Out` still drains normally. Key and count hold their values.
- `load` effects:
  - `key` <= seed, with the 0x00 to 0x01 substitution.
  - `byte_cnt` <= 0.
  - `out_valid` <= 0; a pending output byte is discarded.
  - `load` has priority over any same-cycle transfer, because `in_ready` is forced to 0.
- The count saturates at `FRAME_LEN`, since DONE blocks further input. No wrap is possible.
- In DONE, the final output byte still drains through `out_ready`.

## Timing
- Reset values: state IDLE, `Out`=0x00, `out_valid`=0, `in_ready`=0, `key`=0x01, `byte_cnt`=0, `frame_done`=0.
- Reset is asynchronous; assertion in mid-frame aborts the frame immediately.
- Latency: the byte accepted in cycle t appears on `Out` with `out_valid`=1 in cycle t+1.
- Throughput: 1 byte/cycle when `out_ready` is held at 1.
- `in_ready` is combinational from state, `en`, `load`, `out_valid` and `out_ready`. It has no combinational path from `in_valid`.
- `load` in cycle t: RUN and the new key are in effect from cycle t+1. The first acceptance can happen in cycle t+1.
- `frame_done` goes high in the cycle after the last acceptance, together with `out_valid` for the last byte.

## Structure
- Shared package `xor_pkg` holds:
  - the LFSR tap mask 8'hB8 (bits 7,5,4,3);
  - the zero-seed substitute 8'h01;
  - the function `lfsr_next(key)`;
  - the FSM state enum {IDLE, RUN, DONE}.
- The encoder and decoder both import `xor_pkg`.
- Sub-module `xor_keygen` contains the key register, the seed load with substitution, and the advance on a `step` input. It exposes the current key combinationally.

## Test plan
- Basic frame: reset; `load`=1, `SV`=0x01; then send `IN` = 0x41, 0x42, 0x43, 0x44, 0x45 with `out_ready`=1.
  - Required `Out`: 0x40, 0x40, 0x47, 0x4C, 0x54.
  - `byte_cnt` steps 1..5.
- Zero seed: `SV`=0x00, `IN`=0x41.
  - Required `Out`=0x40, the same as seed 0x01.
- Backpressure: hold `out_ready`=0 after the first byte.
  - `in_ready` drops to 0 and `Out` stays 0x40 stable.
  - Key does not advance; after release, the next byte 0x42 still decodes to 0x40.
- Frame end, `FRAME_LEN`=4: after 4 accepted bytes, `frame_done`=1, `in_ready`=0 and `byte_cnt`=4.
  - `load` returns the block to RUN with `byte_cnt`=0 and `frame_done`=0.
- Mid-stream `load` while `out_valid`=1 and `in_valid`=1:
  - the pending output is dropped;
  - the same-cycle input is not accepted;
  - the next byte decodes with the new seed.
- `en`=0 with `in_valid`=1 for 3 cycles: no acceptance and `byte_cnt` unchanged. Then reset mid-frame: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/xor_pkg.sv
// Shared definitions for the XOR stream cipher path (encoder and decoder).
// Keystream is an 8-bit Fibonacci LFSR for x^8+x^6+x^5+x^4+1.
package xor_pkg;

  localparam logic [7:0] LfsrTaps    = 8'hB8;
  localparam logic [7:0] ZeroSeedSub = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } xor_state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] key);
    return {key[6:0], ^(key & LfsrTaps)};
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed is remapped.
  function automatic logic [7:0] seed_fix(input logic [7:0] seed);
    return (seed == 8'h00) ? ZeroSeedSub : seed;
  endfunction

endpackage

// File: rtl/xor_keygen.sv
// Keystream register: seed load with zero substitution, one LFSR step per accepted byte.
module xor_keygen
  import xor_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       step_i,
  output logic [7:0] key_o
);

  logic [7:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (load_i) begin
      key_d = seed_fix(seed_i);
    end else if (step_i) begin
      key_d = lfsr_next(key_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= ZeroSeedSub;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_o = key_q;

endmodule

// File: rtl/xor_dec.sv
// Byte-stream XOR decryptor: valid/ready in, one registered output stage, fixed-length frames
// that stop in DONE until the next key load.
module xor_dec
  import xor_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] SV,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] IN,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] Out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] byte_cnt,
  output logic       frame_done
);

  localparam logic [7:0] FrameLenB = FRAME_LEN[7:0];

  xor_state_e state_q, state_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] key;
  logic       xfer;

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = (state_q == RUN) && en && !load && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  xor_keygen u_keygen (
    .clk_i  (CLK),
    .rst_ni (RSTn),
    .load_i (load),
    .seed_i (SV),
    .step_i (xfer),
    .key_o  (key)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    byte_cnt_d  = byte_cnt_q;
    if (load) begin
      state_d     = RUN;
      out_valid_d = 1'b0;
      byte_cnt_d  = 8'd0;
    end else if (xfer) begin
      out_d       = IN ^ key;
      out_valid_d = 1'b1;
      byte_cnt_d  = byte_cnt_q + 8'd1;
      if (byte_cnt_q + 8'd1 == FrameLenB) begin
        state_d = DONE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      byte_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign Out        = out_q;
  assign out_valid  = out_valid_q;
  assign byte_cnt   = byte_cnt_q;
  assign frame_done = (state_q == DONE);

`ifndef SYNTHESIS
  a_cnt_bound: assert property (@(posedge CLK) disable iff (!RSTn) byte_cnt_q <= FrameLenB);
  a_load_blocks: assert property (@(posedge CLK) disable iff (!RSTn) load |-> !in_ready);
`endif

endmodule

// File: tb/tb_xor_dec.sv
// Self-checking bench for xor_dec: two instances (16- and 4-byte frames) share one stimulus.
module tb_xor_dec;

  logic       CLK, RSTn;
  logic [7:0] SV, IN;
  logic       load, en, in_valid, out_ready;

  logic [7:0] d_out [2];
  logic       d_ov  [2];
  logic       d_ir  [2];
  logic [7:0] d_cnt [2];
  logic       d_fd  [2];

  xor_dec #(.FRAME_LEN(16)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .SV(SV), .load(load), .en(en), .IN(IN), .in_valid(in_valid),
    .in_ready(d_ir[0]), .Out(d_out[0]), .out_valid(d_ov[0]), .out_ready(out_ready),
    .byte_cnt(d_cnt[0]), .frame_done(d_fd[0])
  );

  xor_dec #(.FRAME_LEN(4)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .SV(SV), .load(load), .en(en), .IN(IN), .in_valid(in_valid),
    .in_ready(d_ir[1]), .Out(d_out[1]), .out_valid(d_ov[1]), .out_ready(out_ready),
    .byte_cnt(d_cnt[1]), .frame_done(d_fd[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 run, 2 done. Key is derived from seed and byte index, not stored.
  int m_mode [2];
  int m_seed [2];
  int m_cnt  [2];
  int m_out  [2];
  int m_ov   [2];

  function automatic int flen(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int keystream(input int seed, input int n);
    int k;
    int fb;
    k = seed;
    for (int j = 0; j < n; j++) begin
      fb = ((k >> 7) ^ (k >> 5) ^ (k >> 4) ^ (k >> 3)) & 1;
      k  = ((k << 1) & 255) | fb;
    end
    return k;
  endfunction

  function automatic bit m_ready(input int i);
    return (m_mode[i] == 1) && en && !load && ((m_ov[i] == 0) || out_ready);
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0; m_seed[i] <= 1; m_cnt[i] <= 0; m_out[i] <= 0; m_ov[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load) begin
          m_mode[i] <= 1;
          m_seed[i] <= (SV == 8'h00) ? 1 : int'(SV);
          m_cnt[i]  <= 0;
          m_ov[i]   <= 0;
        end else if (in_valid && m_ready(i)) begin
          m_out[i] <= (int'(IN) ^ keystream(m_seed[i], m_cnt[i])) & 255;
          m_ov[i]  <= 1;
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == flen(i)) m_mode[i] <= 2;
        end else if (out_ready) begin
          m_ov[i] <= 0;
        end
      end
    end
  end

  // ---------------- literal expectations (set by stimulus, checked at next negedge) ----------
  localparam int SOut = 0, SOv = 1, SIr = 2, SCnt = 3, SFd = 4;
  int    n_lit;
  int    lit_inst [8];
  int    lit_sig  [8];
  int    lit_exp  [8];
  string lit_name [8];

  task automatic lit(input int inst, input int sig, input int exp, input string nm);
    lit_inst[n_lit] = inst;
    lit_sig[n_lit]  = sig;
    lit_exp[n_lit]  = exp;
    lit_name[n_lit] = nm;
    n_lit++;
  endtask

  function automatic int get_sig(input int inst, input int sig);
    case (sig)
      SOut:    return int'(d_out[inst]);
      SOv:     return int'(d_ov[inst]);
      SIr:     return int'(d_ir[inst]);
      SCnt:    return int'(d_cnt[inst]);
      default: return int'(d_fd[inst]);
    endcase
  endfunction

  // ---------------- compare process ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d.Out", i),        int'(d_out[i]), m_out[i]);
      chk($sformatf("dut%0d.out_valid", i),  int'(d_ov[i]),  m_ov[i]);
      chk($sformatf("dut%0d.in_ready", i),   int'(d_ir[i]),  int'(m_ready(i)));
      chk($sformatf("dut%0d.byte_cnt", i),   int'(d_cnt[i]), m_cnt[i]);
      chk($sformatf("dut%0d.frame_done", i), int'(d_fd[i]),  int'(m_mode[i] == 2));
    end
    for (int j = 0; j < n_lit; j++) begin
      chk($sformatf("lit dut%0d %s", lit_inst[j], lit_name[j]),
          get_sig(lit_inst[j], lit_sig[j]), lit_exp[j]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    n_lit = 0;
  endtask

  logic [7:0] basic_in  [5];
  logic [7:0] basic_exp [5];

  initial begin
    basic_in  = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    basic_exp = '{8'h40, 8'h40, 8'h47, 8'h4C, 8'h54};
    n_lit = 0;
    RSTn = 1'b0; SV = 8'h00; IN = 8'h00; load = 1'b0; en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge CLK);
    #1;
    lit(0, SOut, 8'h00, "reset Out"); lit(0, SOv, 0, "reset out_valid");
    lit(0, SIr, 0, "reset in_ready"); lit(0, SCnt, 0, "reset byte_cnt");
    lit(0, SFd, 0, "reset frame_done");
    tick();
    RSTn = 1'b1;
    tick();

    // Basic frame, seed 0x01
    en = 1'b1; out_ready = 1'b1; load = 1'b1; SV = 8'h01;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; IN = basic_in[i];
      if (i == 0) lit(0, SIr, 1, "in_ready after load");
      if (i > 0) begin
        lit(0, SOut, int'(basic_exp[i-1]), $sformatf("basic Out[%0d]", i - 1));
        lit(0, SCnt, i, $sformatf("basic byte_cnt %0d", i));
      end
      if (i == 4) begin
        lit(1, SFd, 1, "frame end frame_done");
        lit(1, SIr, 0, "frame end in_ready");
        lit(1, SCnt, 4, "frame end byte_cnt");
        lit(1, SOv, 1, "frame end out_valid");
      end
      tick();
    end
    in_valid = 1'b0;
    lit(0, SOut, int'(basic_exp[4]), "basic Out[4]");
    lit(0, SCnt, 5, "basic byte_cnt 5");
    tick();

    // Zero seed behaves as 0x01; load also releases the 4-byte instance from DONE
    load = 1'b1; SV = 8'h00;
    tick();
    load = 1'b0; in_valid = 1'b1; IN = 8'h41;
    lit(1, SCnt, 0, "reload byte_cnt"); lit(1, SFd, 0, "reload frame_done");
    lit(1, SIr, 1, "reload in_ready");
    tick();
    in_valid = 1'b0;
    lit(0, SOut, 8'h40, "zero seed Out");
    lit(1, SCnt, 1, "after reload byte_cnt");
    tick();

    // Backpressure
    load = 1'b1; SV = 8'h01;
    tick();
    load = 1'b0; in_valid = 1'b1; IN = 8'h41; out_ready = 1'b0;
    tick();
    IN = 8'h42;
    lit(0, SOut, 8'h40, "bp Out held"); lit(0, SOv, 1, "bp out_valid");
    lit(0, SIr, 0, "bp in_ready");
    tick();
    lit(0, SOut, 8'h40, "bp Out stable"); lit(0, SIr, 0, "bp in_ready 2");
    lit(0, SCnt, 1, "bp byte_cnt");
    tick();
    out_ready = 1'b1;
    lit(0, SIr, 1, "bp release in_ready");
    tick();
    in_valid = 1'b0;
    lit(0, SOut, 8'h40, "bp next byte Out"); lit(0, SCnt, 2, "bp byte_cnt 2");
    tick();

    // Mid-stream load with pending output and same-cycle input
    in_valid = 1'b1; IN = 8'h41; out_ready = 1'b0;
    tick();
    load = 1'b1; SV = 8'h5A; IN = 8'h99;
    lit(0, SOv, 1, "pre-load pending"); lit(0, SOut, 8'h45, "pre-load Out");
    lit(0, SIr, 0, "load blocks in_ready");
    tick();
    load = 1'b0; out_ready = 1'b1;
    lit(0, SOv, 0, "load drops pending"); lit(0, SCnt, 0, "load clears byte_cnt");
    tick();
    in_valid = 1'b0;
    lit(0, SOut, 8'hC3, "new seed Out"); lit(0, SOv, 1, "new seed out_valid");
    lit(0, SCnt, 1, "new seed byte_cnt");
    tick();

    // en=0 blocks acceptance, pending output still drains
    in_valid = 1'b1; IN = 8'h10; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lit(0, SIr, 0, "en=0 in_ready"); lit(0, SCnt, 1, "en=0 byte_cnt");
      if (i == 1) lit(0, SOv, 0, "en=0 drained");
      tick();
    end
    en = 1'b1;
    lit(0, SIr, 1, "en=1 in_ready");
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    lit(0, SOut, 8'hA4, "key held under en=0"); lit(0, SCnt, 2, "en=1 byte_cnt");
    tick();

    // Asynchronous reset mid-frame, checked before any clock edge
    RSTn = 1'b0;
    lit(0, SOut, 8'h00, "async rst Out"); lit(0, SOv, 0, "async rst out_valid");
    lit(0, SIr, 0, "async rst in_ready"); lit(0, SCnt, 0, "async rst byte_cnt");
    lit(0, SFd, 0, "async rst frame_done");
    tick();
    RSTn = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
